// File: rtl/video_pkg.sv
// Shared video definitions: sprite attribute layout, slot count and scheduler states.
package video_pkg;

    localparam int unsigned ATTR_W  = 32;
    localparam int unsigned SLOTS   = 4;

    localparam int unsigned X_LSB   = 0;
    localparam int unsigned X_MSB   = 8;
    localparam int unsigned Y_LSB   = 9;
    localparam int unsigned Y_MSB   = 16;
    localparam int unsigned IMG_LSB = 17;
    localparam int unsigned IMG_MSB = 25;
    localparam int unsigned RGB_LSB = 26;
    localparam int unsigned RGB_MSB = 28;
    localparam int unsigned RSV_LSB = 29;
    localparam int unsigned RSV_MSB = 30;
    localparam int unsigned EN_BIT  = 31;

    typedef struct packed {
        logic       en;
        logic [1:0] rsv;
        logic [2:0] rgb;
        logic [8:0] img;
        logic [7:0] y;
        logic [8:0] x;
    } sprite_attr_t;

    typedef enum logic {
        SCHED_IDLE = 1'b0,
        SCHED_SCAN = 1'b1
    } sched_state_e;

    // 9-bit compare so y + height never wraps back onto low lines
    function automatic logic attr_hit(input sprite_attr_t a, input logic [7:0] line,
                                      input logic [8:0] height);
        logic [8:0] line9;
        logic [8:0] y9;
        line9 = {1'b0, line};
        y9    = {1'b0, a.y};
        return a.en && (line9 >= y9) && (line9 < (y9 + height));
    endfunction

endpackage

// File: rtl/sprite_attr_table.sv
// Sprite attribute register file: byte-strobed write port, combinational read port.
module sprite_attr_table
    import video_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 16
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           wr_en,
    input  logic [$clog2(NUM_SPRITES)-1:0] wr_addr,
    input  logic [3:0]                     wr_strb,
    input  logic [ATTR_W-1:0]              wr_data,
    input  logic [$clog2(NUM_SPRITES)-1:0] rd_addr,
    output logic [ATTR_W-1:0]              rd_data
);

    logic [ATTR_W-1:0] mem [NUM_SPRITES];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < int'(NUM_SPRITES); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Reads see the pre-write contents when addressed in the write cycle
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sprite_scheduler.sv
// Per-scanline sprite evaluator: scans the attribute table during hblank and
// publishes the first SLOTS hitting sprites to the sprite units on commit.
module sprite_scheduler
    import video_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 16,
    parameter int unsigned SPRITE_H    = 16
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           wr_en,
    input  logic [$clog2(NUM_SPRITES)-1:0] wr_addr,
    input  logic [3:0]                     wr_strb,
    input  logic [ATTR_W-1:0]              wr_data,
    input  logic                           eval_start,
    input  logic [7:0]                     eval_line,
    input  logic                           commit,
    output logic [SLOTS*ATTR_W-1:0]        slot_cfg,
    output logic [SLOTS-1:0]               slot_valid,
    output logic                           overflow,
    output logic                           busy,
    output logic                           late,
    input  logic                           clr_late
);

    localparam int unsigned IDX_W = $clog2(NUM_SPRITES);
    localparam int unsigned CNT_W = 3;

    sched_state_e                         state_q, state_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic [7:0]                           line_q, line_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic [SLOTS-1:0][ATTR_W-1:0]         pend_cfg_q, pend_cfg_d;
    logic [SLOTS-1:0]                     pend_vld_q, pend_vld_d;
    logic                                 pend_ovf_q, pend_ovf_d;
    logic [ATTR_W-1:0]                    rd_data;
    logic                                 hit_c;

    sprite_attr_table #(.NUM_SPRITES(NUM_SPRITES)) u_table (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_strb (wr_strb),
        .wr_data (wr_data),
        .rd_addr (idx_q),
        .rd_data (rd_data)
    );

    assign hit_c = attr_hit(sprite_attr_t'(rd_data), line_q, 9'(SPRITE_H));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= SCHED_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Scan step, commit abort and scan (re)start
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        line_d     = line_q;
        cnt_d      = cnt_q;
        pend_cfg_d = pend_cfg_q;
        pend_vld_d = pend_vld_q;
        pend_ovf_d = pend_ovf_q;

        if (state_q == SCHED_SCAN) begin
            if (hit_c && (cnt_q < CNT_W'(SLOTS))) begin
                pend_cfg_d[cnt_q[1:0]] = rd_data;
                pend_vld_d[cnt_q[1:0]] = 1'b1;
                cnt_d                  = cnt_q + CNT_W'(1);
            end
            if (hit_c && (cnt_q == CNT_W'(SLOTS))) begin
                pend_ovf_d = 1'b1;
                state_d    = SCHED_IDLE;
            end else if (idx_q == IDX_W'(NUM_SPRITES - 1)) begin
                state_d = SCHED_IDLE;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
            if (commit) begin
                state_d = SCHED_IDLE;
            end
        end

        if (eval_start) begin
            state_d    = SCHED_SCAN;
            line_d     = eval_line;
            idx_d      = '0;
            cnt_d      = '0;
            pend_cfg_d = '0;
            pend_vld_d = '0;
            pend_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            idx_q      <= '0;
            line_q     <= '0;
            cnt_q      <= '0;
            pend_cfg_q <= '0;
            pend_vld_q <= '0;
            pend_ovf_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            line_q     <= line_d;
            cnt_q      <= cnt_d;
            pend_cfg_q <= pend_cfg_d;
            pend_vld_q <= pend_vld_d;
            pend_ovf_q <= pend_ovf_d;
        end
    end

    // Published set is held for the whole line; commit samples the pre-update pending set
    always_ff @(posedge clk) begin
        if (!resetn) begin
            slot_cfg   <= '0;
            slot_valid <= '0;
            overflow   <= 1'b0;
            late       <= 1'b0;
        end else begin
            if (commit) begin
                slot_cfg   <= pend_cfg_q;
                slot_valid <= pend_vld_q;
                overflow   <= pend_ovf_q;
            end
            if (commit && (state_q == SCHED_SCAN)) begin
                late <= 1'b1;
            end else if (clr_late) begin
                late <= 1'b0;
            end
        end
    end

    assign busy = (state_q == SCHED_SCAN);

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed and randomized checks of sprite_scheduler against a table-level model.
module tb_sprite_scheduler;

    localparam int NUM = 16;
    localparam int SH  = 16;

    logic         clk = 1'b0;
    logic         resetn;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [3:0]   wr_strb;
    logic [31:0]  wr_data;
    logic         eval_start;
    logic [7:0]   eval_line;
    logic         commit;
    logic [127:0] slot_cfg;
    logic [3:0]   slot_valid;
    logic         overflow;
    logic         busy;
    logic         late;
    logic         clr_late;

    int checks = 0;
    int errors = 0;

    logic [31:0] tbl [NUM];

    sprite_scheduler #(.NUM_SPRITES(NUM), .SPRITE_H(SH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_strb    (wr_strb),
        .wr_data    (wr_data),
        .eval_start (eval_start),
        .eval_line  (eval_line),
        .commit     (commit),
        .slot_cfg   (slot_cfg),
        .slot_valid (slot_valid),
        .overflow   (overflow),
        .busy       (busy),
        .late       (late),
        .clr_late   (clr_late)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] w, input int line);
        int y;
        y = int'(w[16:9]);
        return (w[31] == 1'b1) && (line >= y) && (line < y + SH);
    endfunction

    // First four hits in index order; a fifth hit ends the scan early
    task automatic model_eval(input int line, output logic [127:0] cfg, output logic [3:0] vld,
                              output logic ovf, output int cyc);
        int  n;
        bit  done;
        cfg = '0; vld = '0; ovf = 1'b0; cyc = NUM; n = 0; done = 0;
        for (int i = 0; i < NUM; i++) begin
            if (!done && model_hit(tbl[i], line)) begin
                if (n < 4) begin
                    cfg[32*n +: 32] = tbl[i];
                    vld[n] = 1'b1;
                    n++;
                end else begin
                    ovf = 1'b1;
                    cyc = i + 1;
                    done = 1;
                end
            end
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        for (int i = 0; i < NUM; i++) tbl[i] = '0;
    endtask

    task automatic cpu_write(input int addr, input logic [3:0] strb, input logic [31:0] data);
        wr_en = 1'b1; wr_addr = 4'(addr); wr_strb = strb; wr_data = data;
        tick();
        wr_en = 1'b0;
        for (int b = 0; b < 4; b++) if (strb[b]) tbl[addr][8*b +: 8] = data[8*b +: 8];
    endtask

    function automatic logic [31:0] mk(input bit en, input int y, input int salt);
        logic [31:0] w;
        w = 32'(salt) & 32'h7FFE_01FF;
        w[16:9] = 8'(y);
        w[31] = en;
        return w;
    endfunction

    task automatic start_scan(input int line);
        eval_start = 1'b1; eval_line = 8'(line);
        tick();
        eval_start = 1'b0;
    endtask

    // Counts busy cycles after eval_start; a stuck scan counts as a failure
    task automatic scan_wait(input int line, output int cyc);
        start_scan(line);
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            tick();
        end
        if (cyc >= 200) begin
            errors++;
            $error("FAIL scan_timeout observed=%0d expected=<200", cyc);
        end
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic scan_and_check(input string tag, input int line, input bit chk_cyc);
        logic [127:0] ecfg;
        logic [3:0]   evld;
        logic         eovf;
        int           ecyc, cyc;
        model_eval(line, ecfg, evld, eovf, ecyc);
        scan_wait(line, cyc);
        do_commit();
        if (chk_cyc) chk({tag, "_cycles"}, 128'(cyc), 128'(ecyc));
        chk({tag, "_valid"}, 128'(slot_valid), 128'(evld));
        chk({tag, "_cfg"}, slot_cfg, ecfg);
        chk({tag, "_ovf"}, 128'(overflow), 128'(eovf));
    endtask

    initial begin
        logic [127:0] ecfg;
        logic [3:0]   evld;
        logic         eovf;
        logic [31:0]  w4;
        int           ecyc, cyc, line, y;

        resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_strb = '0; wr_data = '0;
        eval_start = 1'b0; eval_line = '0; commit = 1'b0; clr_late = 1'b0;
        do_reset();

        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_valid", 128'(slot_valid), 128'(0));
        chk("rst_cfg", slot_cfg, 128'(0));
        chk("rst_ovf", 128'(overflow), 128'(0));
        chk("rst_late", 128'(late), 128'(0));

        // Reset in the middle of a scan
        for (int i = 0; i < 3; i++) cpu_write(i, 4'hF, mk(1, 0, 32'h1234 + i));
        start_scan(5);
        repeat (4) tick();
        resetn = 1'b0;
        tick();
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_valid", 128'(slot_valid), 128'(0));
        chk("midrst_late", 128'(late), 128'(0));
        resetn = 1'b1;
        for (int i = 0; i < NUM; i++) tbl[i] = '0;
        scan_and_check("midrst_rescan", 5, 1);
        chk("midrst_rescan_const", 128'(slot_valid), 128'(0));

        // Basic selection
        do_reset();
        cpu_write(2, 4'hF, mk(1, 10, 32'h0ABC_0123));
        cpu_write(9, 4'hF, mk(1, 10, 32'h3C5A_00F0));
        scan_and_check("basic", 12, 1);
        chk("basic_const_valid", 128'(slot_valid), 128'(4'b0011));
        chk("basic_const_slot1", 128'(slot_cfg[63:32]), 128'(tbl[9]));

        // Overflow ends the scan on the fifth hit
        do_reset();
        for (int i = 0; i < 6; i++) cpu_write(i, 4'hF, mk(1, 0, 32'h55 * (i + 1)));
        scan_and_check("ovf", 15, 1);
        chk("ovf_const", 128'(overflow), 128'(1));

        // Hit window boundaries
        do_reset();
        cpu_write(0, 4'hF, mk(1, 100, 32'h77));
        scan_and_check("bnd99", 99, 0);
        scan_and_check("bnd100", 100, 0);
        scan_and_check("bnd115", 115, 0);
        scan_and_check("bnd116", 116, 0);
        chk("bnd116_const", 128'(slot_valid), 128'(0));
        cpu_write(1, 4'hF, mk(1, 250, 32'h99));
        scan_and_check("bnd_wrap", 4, 0);
        chk("bnd_wrap_const", 128'(slot_valid), 128'(0));
        cpu_write(0, 4'hF, mk(0, 100, 32'h77));
        scan_and_check("bnd_dis", 100, 0);

        // Commit during a scan publishes the partial set and sets late
        do_reset();
        cpu_write(0, 4'hF, mk(1, 50, 32'h11));
        cpu_write(7, 4'hF, mk(1, 45, 32'h22));
        start_scan(52);
        tick();
        tick();
        do_commit();
        chk("late_valid", 128'(slot_valid), 128'(4'b0001));
        chk("late_cfg", slot_cfg, {96'b0, tbl[0]});
        chk("late_busy", 128'(busy), 128'(0));
        chk("late_set", 128'(late), 128'(1));
        tick();
        chk("late_sticky", 128'(late), 128'(1));
        clr_late = 1'b1;
        tick();
        clr_late = 1'b0;
        chk("late_clr", 128'(late), 128'(0));

        // Write to the entry being examined is seen only by the next scan
        do_reset();
        cpu_write(4, 4'hF, mk(0, 20, 32'h0F0F_0F0F));
        w4 = (tbl[4] & 32'h00FF_FFFF) | 32'h8000_0000;
        start_scan(20);
        repeat (4) tick();
        wr_en = 1'b1; wr_addr = 4'd4; wr_strb = 4'b1000; wr_data = 32'h80FF_FFFF;
        tick();
        wr_en = 1'b0;
        tbl[4] = w4;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin cyc++; tick(); end
        do_commit();
        chk("haz_first_valid", 128'(slot_valid), 128'(0));
        scan_and_check("haz_second", 20, 1);
        chk("haz_strb_word", 128'(slot_cfg[31:0]), 128'(w4));

        // Randomized tables and lines
        for (int it = 0; it < 25; it++) begin
            do_reset();
            line = int'($urandom_range(0, 239));
            for (int i = 0; i < NUM; i++) begin
                y = line - 20 + int'($urandom_range(0, 26));
                if (y < 0) y = 0;
                if (y > 255) y = 255;
                cpu_write(i, 4'hF, mk($urandom_range(0, 3) != 0, y, int'($urandom)));
            end
            if ($urandom_range(0, 1) == 1) cpu_write(int'($urandom_range(0, NUM - 1)),
                                                     4'($urandom_range(1, 15)), $urandom);
            scan_and_check($sformatf("rnd%0d", it), line, 1);
            model_eval(line, ecfg, evld, eovf, ecyc);
            // Commit coinciding with a new scan publishes the old pending set
            eval_start = 1'b1; eval_line = 8'(line); commit = 1'b1;
            tick();
            eval_start = 1'b0; commit = 1'b0;
            chk($sformatf("rnd%0d_repub_cfg", it), slot_cfg, ecfg);
            chk($sformatf("rnd%0d_repub_busy", it), 128'(busy), 128'(1));
            chk($sformatf("rnd%0d_repub_late", it), 128'(late), 128'(0));
            cyc = 0;
            while (busy === 1'b1 && cyc < 200) begin cyc++; tick(); end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_scheduler.md
Name: sprite_scheduler

Overview:
Per-scanline sprite evaluator. It multiplexes a table of NUM_SPRITES sprite attribute words onto the 4 hardware sprite units of the video block.
- During horizontal blanking it scans the table in index order and picks the first 4 sprites that cover the next line.
- At line start it presents their configuration words to the sprite units.
- Sits between the CPU iomem register decode and the video block's sprite configuration inputs.

Parameters:
NUM_SPRITES, 16, number of attribute table entries (power of 2, 4..64)
SPRITE_H, 16, sprite height in half-resolution lines
SLOTS, 4, hardware sprite units fed (fixed; not overridable)

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
wr_en  in  1  CPU write to attribute table
wr_addr  in  log2(NUM_SPRITES)  table entry index
wr_strb  in  4  byte write strobes
wr_data  in  32  attribute word
eval_start  in  1  one-cycle pulse: begin scan for eval_line
eval_line  in  8  half-res line to evaluate (0..239), sampled on eval_start
commit  in  1  one-cycle pulse at line start: publish pending result
slot_cfg  out  128  4 x 32-bit config words, slot 0 in bits [31:0]
slot_valid  out  4  slot k holds a sprite
overflow  out  1  more than 4 sprites hit the committed line
busy  out  1  scan in progress
late  out  1  sticky: commit arrived while scanning
clr_late  in  1  clears late

Behaviour:
- Reset, sync active-low: all table entries = 0 (disabled), slot_cfg = 0, slot_valid = 0, overflow = 0, busy = 0, late = 0, state IDLE, pending set cleared.
- Attribute word fields:
  - x[8:0]
  - y[16:9]
  - image[25:17]
  - rgb[28:26]
  - bits[30:29] reserved, stored
  - enable[31]
- Table writes:
  - Byte-strobed, accepted in any state, effective next cycle.
  - A scan read of the entry written in the same cycle sees the old value.
- Hit rule: enable && eval_line >= y && eval_line < y + SPRITE_H, computed in 9 bits. There is no wrap: y = 250, SPRITE_H = 16 never hits line 0.
- FSM states: IDLE, SCAN.
  - IDLE -> SCAN on eval_start: latch eval_line, idx = 0, pending count = 0, pending valid = 0, pending overflow = 0.
  - In SCAN, entry idx is examined in cycle idx+1 after eval_start.
    - Hit with count < 4: pending[count] = entry, valid bit set, count++.
    - Hit with count == 4: pending overflow = 1, go to IDLE immediately.
    - idx == NUM_SPRITES-1: go to IDLE.
    - Otherwise idx++.
  - Worst-case scan time is NUM_SPRITES cycles. busy = (state == SCAN).
- Priority: lower index wins the lower slot number. Slot order is fixed by index order.
- commit:
  - Next cycle: slot_cfg <= pending words, slot_valid <= pending valid, overflow <= pending overflow.
  - Outputs are otherwise held stable for the whole line.
  - Commit in SCAN: publishes partial result, aborts scan (-> IDLE), sets late.
  - Commit in IDLE without a new scan: republishes the same pending set.
- Simultaneous commit + eval_start: commit uses the pre-clear pending set, then the new scan starts (pending cleared).
- eval_start during SCAN: restart the scan from idx 0 with new eval_line. late is unaffected.
- clr_late and a late-setting commit in the same cycle: set wins.
- Unused slot_cfg words are driven 0.

Decomposition:
- Shared package video_pkg:
  - Attribute field position constants (X_LSB/MSB, Y_LSB/MSB, IMG, RGB = 26..28, EN = 31).
  - SLOTS = 4.
  - Scheduler state encoding.
- The video block reuses the same RGB field constants.
- One sub-module: sprite_attr_table, the NUM_SPRITES x 32 register file with byte-strobe write port and combinational read port.
- Hit compare and FSM stay in sprite_scheduler.

Test Plan:
- Reset-mid-scan → clean reset: enable 3 sprites, pulse eval_start, assert resetn = 0 at scan cycle 5 → next cycle busy = 0, slot_valid = 0, late = 0; table reads back 0 (no hits on subsequent scans).
- Basic selection:
  - Stimulus: entries 2 and 9 enabled with y = 10, line 12.
  - Required: busy for 16 cycles; after commit, slot_valid = 4'b0011, slot 0 = entry 2 word, slot 1 = entry 9 word, overflow = 0.
- Overflow:
  - Stimulus: entries 0..5 enabled with y = 0, line 15.
  - Required: slots = entries 0..3, overflow = 1, busy drops after 5 cycles.
- Boundaries:
  - y = 100: line 99 → no hit, line 100 → hit, line 115 → hit, line 116 → no hit.
  - y = 250, line 4: no hit.
  - Disabled entry with y = 100 at line 100: no hit.
- Late commit: eval_start, then commit at scan cycle 3 with hits at entries 0 and 7 → slot_valid = 4'b0001, late = 1 until clr_late.
- Write hazard:
  - Stimulus: CPU write sets entry 4 enable in the same cycle the scan examines entry 4.
  - Required: entry 4 is not selected this line; selected on the next scan.
  - Byte strobe 4'b1000 alters only bits [31:24].
